// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the stage-buffer defaults.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   localparam int LC3B_STAGE_DEPTH_DEFAULT = 2;

   typedef logic [$clog2(LC3B_STAGE_DEPTH_DEFAULT+1)-1:0] lc3b_stage_count;

   // Control bundle carried between pipeline stages alongside the datapath.
   typedef struct packed {
      logic [3:0] opcode;
      logic       ld_reg;
      logic       ld_cc;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] dest_reg;
      logic [1:0] alu_op;
   } lc3b_control_word;

endpackage

// File: rtl/lc3b_stage_ptr.sv
// Wrapping FIFO pointer: advances on i_inc, returns to zero on i_clear.
module lc3b_stage_ptr #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_inc,
   input  logic                     i_clear,
   output logic [$clog2(DEPTH)-1:0] o_ptr
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] r_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (i_clear) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/lc3b_stage_buffer.sv
// Valid/ready FIFO between LC-3b pipeline stages.
// Optional zero-latency pass-through when empty: define LC3B_STAGE_BYPASS_EN.
module lc3b_stage_buffer
   import lc3b_types::*;
#(
   parameter int WIDTH = $bits(lc3b_word),
   parameter int DEPTH = LC3B_STAGE_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [AW-1:0]    w_wr_ptr;
   logic [AW-1:0]    w_rd_ptr;
   logic             w_push;
   logic             w_pop;
   logic             w_pass;
   logic             w_wr;
   logic             w_rd;

   assign count = r_count;
   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);

   // in_ready never looks at out_ready, so a full buffer cannot refill on the pop cycle.
   assign in_ready = reset_n && !full && !flush;

`ifdef LC3B_STAGE_BYPASS_EN
   assign out_valid = reset_n && !flush && (!empty || in_valid);
   assign out_data  = !out_valid ? '0 : (empty ? in_data : r_mem[w_rd_ptr]);
   assign w_pass    = empty && w_push && out_ready;
`else
   assign out_valid = reset_n && !flush && !empty;
   assign out_data  = out_valid ? r_mem[w_rd_ptr] : '0;
   assign w_pass    = 1'b0;
`endif

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;
   assign w_wr   = w_push && !w_pass;
   assign w_rd   = w_pop && !empty;

   lc3b_stage_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_wr),
      .i_clear (flush),
      .o_ptr   (w_wr_ptr)
   );

   lc3b_stage_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_rd),
      .i_clear (flush),
      .o_ptr   (w_rd_ptr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; validity is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_wr_ptr] <= in_data;
      end
   end

endmodule

// File: doc/lc3b_stage_buffer.md
LC3B_STAGE_BUFFER -- requirements
Module: lc3b_stage_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, payload bits per entry (lc3b_word width); legal range 1..256.
REQ-002 SHALL have parameter DEPTH, default 2, entry count; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1  buffer accepts this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port out_data  output  WIDTH  oldest payload.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  stored entries.
REQ-013 SHALL have ports full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-014 SHALL act as a DEPTH-entry FIFO; push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-015 in_ready SHALL equal !full && !flush, derived from registered state only (no combinational out_ready->in_ready path).
REQ-016 Write and read pointers SHALL increment by one per push/pop and wrap DEPTH-1 -> 0.
REQ-017 Push and pop in same cycle with 1 <= count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-018 When full, a pop SHALL NOT admit a push that cycle; in_ready rises the cycle after the pop.
REQ-019 Registered path: stored entry SHALL appear on out_data with out_valid=1 one cycle after its push.
REQ-020 out_data SHALL be all-zero whenever out_valid=0.
REQ-021 Order SHALL be strictly FIFO; no entry dropped or duplicated except by flush/reset.
REQ-022 flush=1 SHALL force count, pointers to 0 at next edge; flush dominates simultaneous push and pop; out_valid SHALL be 0 during the flush cycle.
REQ-023 in_valid held with in_ready=0 SHALL NOT alter state; in_data is sampled only on push.

Reset
REQ-024 reset_n=0 SHALL immediately force count=0, pointers=0, empty=1, full=0, out_valid=0, out_data=0, in_ready=0 while asserted.
REQ-025 Storage array SHALL NOT require reset.
REQ-026 Reset asserted mid-transfer SHALL discard all entries; first push after release is first out.
REQ-027 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-028 Macro LC3B_STAGE_BYPASS_EN defined: when empty and not flush, out_valid=in_valid and out_data=in_data combinationally; if out_ready=1 the item passes with zero latency and is not stored, count stays 0.
REQ-029 Bypass with out_ready=0 SHALL store the item normally (count 1).
REQ-030 Macro undefined: no in_*->out_* combinational path; minimum latency one cycle per REQ-019.

Structure
REQ-031 lc3b_types SHALL gain constant LC3B_STAGE_DEPTH_DEFAULT (2) and typedef lc3b_stage_count (count width for default depth).
REQ-032 Pointer logic SHALL be sub-module lc3b_stage_ptr (parameter DEPTH; inc, clear inputs; wrapping pointer output), instantiated twice.
REQ-033 Instantiation with WIDTH=$bits(lc3b_control_word) SHALL be supported for pipeline control transport.

Verification
REQ-034 Reset, push 0x1111,0x2222 (DEPTH=2, out_ready=0) -> full=1, in_ready=0, count=2; then out_ready=1 -> outputs 0x1111, 0x2222 in order, empty=1.
REQ-035 DEPTH=4, continuous push/pop for 10 items 0x0001..0x000A -> pointer wrap, order preserved, count never >1 after first.
REQ-036 Full, out_ready=1 and in_valid=1 same cycle -> one pop, no push, count DEPTH-1, in_ready=1 next cycle.
REQ-037 Count 3, flush=1 with in_valid=1 and out_ready=1 -> count=0 next cycle, out_valid=0, pushed item absent.
REQ-038 reset_n low mid-stream with count 2 -> out_valid=0, out_data=0 before next edge; after release push 0xBEEF -> out 0xBEEF.
REQ-039 LC3B_STAGE_BYPASS_EN, empty, in_data 0xA5A5, out_ready=1 -> out_data=0xA5A5 same cycle, count stays 0; macro off -> appears next cycle.
